mac_divider: RTL and testbench

MAC_DIVIDER -- requirements
Module: mac_divider

---
 rtl/mac_divider_if.sv | 24 ++
 rtl/mac_divider.sv | 114 +++++++++++
 tb/tb_mac_divider.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mac_divider_if.sv
// rtl/mac_divider_if.sv - request/response handshake bundle for mac_divider
interface mac_divider_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        err;

  // Requester/consumer side
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, err
  );

  // Divider side
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, err
  );
endinterface

// File: rtl/mac_divider.sv
// rtl/mac_divider.sv - 16/8 unsigned restoring divider, one quotient bit per cycle; MAC_DIV_ZERO_ERR_EN enables divide-by-zero early exit
module mac_divider (
  input logic          clk,
  input logic          reset,
  mac_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  state_t      state_next;

  // work holds the dividend bits still to be consumed (MSB first) while the
  // quotient bits are shifted in at the bottom; after 16 steps it is the quotient
  logic [15:0] work;
  logic [7:0]  dvs;
  logic [7:0]  partial;
  logic [3:0]  step;
  logic [15:0] q_out;
  logic [7:0]  r_out;

  logic [8:0]  shifted;
  logic        fits;
  logic [7:0]  partial_next;
  logic [15:0] work_next;
  logic        early_exit;

`ifdef MAC_DIV_ZERO_ERR_EN
  logic        err_out;
  assign early_exit = (bus.divisor == 8'd0);
  assign bus.err    = err_out;
`else
  assign early_exit = 1'b0;
  assign bus.err    = 1'b0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = q_out;
  assign bus.remainder = r_out;

  // One restoring step: the difference always fits in 8 bits when it is taken,
  // and with a zero divisor the truncation leaves the dividend's low byte
  always_comb begin
    shifted      = {partial, work[15]};
    fits         = (shifted >= {1'b0, dvs});
    partial_next = fits ? (shifted[7:0] - dvs) : shifted[7:0];
    work_next    = {work[14:0], fits};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid) state_next = early_exit ? DONE : BUSY;
      BUSY:    if (step == 4'd15) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers (results only change on entry to DONE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work    <= '0;
      dvs     <= '0;
      partial <= '0;
      step    <= '0;
      q_out   <= '0;
      r_out   <= '0;
`ifdef MAC_DIV_ZERO_ERR_EN
      err_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work    <= bus.dividend;
            dvs     <= bus.divisor;
            partial <= '0;
            step    <= '0;
`ifdef MAC_DIV_ZERO_ERR_EN
            if (early_exit) begin
              q_out   <= '0;
              r_out   <= '0;
              err_out <= 1'b1;
            end
`endif
          end
        end
        BUSY: begin
          work    <= work_next;
          partial <= partial_next;
          step    <= step + 4'd1;
          if (step == 4'd15) begin
            q_out   <= work_next;
            r_out   <= partial_next;
`ifdef MAC_DIV_ZERO_ERR_EN
            err_out <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_divider.sv
// tb/tb_mac_divider.sv - directed and streamed self-checking bench for mac_divider
module tb_mac_divider;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mac_divider_if bus ();

  mac_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, optionally hold backpressure, then transfer
  task automatic run_req(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input int exp_lat, input logic [15:0] eq, input logic [7:0] er,
                         input logic ee, input int hold);
    int lat;
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = 16'h5A5A;
    bus.divisor  = 8'h33;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_quotient"}, 32'(bus.quotient), 32'(eq));
      check({tag, "_hold_remainder"}, 32'(bus.remainder), 32'(er));
      @(negedge clk);
    end
    check({tag, "_quotient"}, 32'(bus.quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(bus.remainder), 32'(er));
    check({tag, "_err"}, 32'(bus.err), 32'(ee));
    check({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_quotient_retained"}, 32'(bus.quotient), 32'(eq));
  endtask

  initial begin
    logic [15:0] qd[$];
    logic [7:0]  qs[$];
    logic [15:0] d;
    logic [7:0]  s;
    logic        accepted;
    logic        seen;
    int          done;
    int          cyc;

    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_quotient", 32'(bus.quotient), 32'd0);
    check("reset_remainder", 32'(bus.remainder), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    run_req("d1000_7", 16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0, 0);
    run_req("dffff_255", 16'hFFFF, 8'd255, 16, 16'd257, 8'd0, 1'b0, 0);
    run_req("d5_9", 16'd5, 8'd9, 16, 16'd0, 8'd5, 1'b0, 0);
    run_req("dffff_1_bp", 16'hFFFF, 8'd1, 16, 16'hFFFF, 8'd0, 1'b0, 10);

    // Abort mid-computation with a reset pulse
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("abort_never_valid", 32'(seen), 32'd0);
    run_req("d300_10", 16'd300, 8'd10, 16, 16'd30, 8'd0, 1'b0, 0);

`ifdef MAC_DIV_ZERO_ERR_EN
    run_req("d1234_0", 16'd1234, 8'd0, 0, 16'd0, 8'd0, 1'b1, 0);
`else
    run_req("d1234_0", 16'd1234, 8'd0, 16, 16'hFFFF, 8'hD2, 1'b0, 0);
`endif
    run_req("d1000_7_again", 16'd1000, 8'd7, 16, 16'd142, 8'd6, 1'b0, 0);

    // Back-to-back stream with in_valid held high and random consumer backpressure
    done          = 0;
    cyc           = 0;
    bus.in_valid  = 1'b1;
    bus.dividend  = 16'($urandom);
    bus.divisor   = 8'($urandom_range(1, 255));
    bus.out_ready = 1'($urandom_range(0, 1));
    while (done < 1000 && cyc < 80000) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (qd.size() > 0) begin
          d = qd.pop_front();
          s = qs.pop_front();
          check("stream_quotient", 32'(bus.quotient), 32'(d / 16'(s)));
          check("stream_remainder", 32'(bus.remainder), 32'(d % 16'(s)));
          check("stream_err", 32'(bus.err), 32'd0);
        end else begin
          check("stream_unexpected_result", 32'd1, 32'(qd.size()));
        end
        done++;
      end
      accepted = (bus.in_ready === 1'b1) && (bus.in_valid === 1'b1);
      if (accepted) begin
        qd.push_back(bus.dividend);
        qs.push_back(bus.divisor);
      end
      @(negedge clk);
      cyc++;
      if (accepted) begin
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom_range(1, 255));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    check("stream_count", 32'(done), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
